sample_scheduler: RTL and testbench

//  Sequences the real-time feedback sampler and shares its snapshot buffer between requesters.

---
 rtl/sample_scheduler_pkg.sv | 14 +
 rtl/sample_scheduler_if.sv | 26 ++
 rtl/sample_scheduler_rr_arbiter.sv | 36 +++
 rtl/sample_scheduler.sv | 158 +++++++++++++++
 tb/tb_sample_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_scheduler_pkg.sv
// Shared types for the sample scheduler: FSM state encoding and block address width.
package sample_sched_pkg;

   localparam int ADDR_W = 5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TRIG    = 3'd1,
      S_WAIT_HI = 3'd2,
      S_WAIT_LO = 3'd3,
      S_GRANT   = 3'd4
   } state_e;

endpackage

// File: rtl/sample_scheduler_if.sv
// Requester and sampler handshake bundle for the sample scheduler.
// master = requesters/sampler side, slave = scheduler side.
interface sample_scheduler_if #(
   parameter int NUM_REQ = 3
);
   import sample_sched_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             rel;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]             gnt;
   logic [ADDR_W-1:0]              blk_addr;
   logic                           do_sample;
   logic                           sample_busy;

   modport master (
      output req, rel, req_addr, sample_busy,
      input  gnt, blk_addr, do_sample
   );

   modport slave (
      input  req, rel, req_addr, sample_busy,
      output gnt, blk_addr, do_sample
   );

endinterface

// File: rtl/sample_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted req scanning upward from ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [ID_W-1:0]    win_idx,
   output logic               win_any
);

   logic [ID_W:0]   cand;
   logic [ID_W-1:0] cidx;

   // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      win_any = |req;
      cand    = '0;
      cidx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         cidx = cand[ID_W-1:0];
         if (req[cidx]) begin
            win_idx      = cidx;
            win_oh       = '0;
            win_oh[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sample_scheduler.sv
// Sample scheduler: round-robin arbitration of snapshot requesters, one-cycle sample
// trigger, busy-window tracking with timeout, and exclusive block-address ownership.
module sample_scheduler import sample_sched_pkg::*; #(
   parameter int          NUM_REQ      = 3,
   parameter logic [15:0] FRESH_CYCLES = 16'd0,
   parameter logic [7:0]  BUSY_TIMEOUT = 8'd32
) (
   input  logic               clk,
   input  logic               reset,
   sample_scheduler_if.slave  bus,
   output logic [15:0]        sample_cnt,
   output logic               timeout_err
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e              state, state_nxt;
   logic [ID_W-1:0]     id_q, id_nxt;
   logic [NUM_REQ-1:0]  own_oh, own_oh_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [7:0]          tmo_cnt;
   logic [15:0]         age;
   logic                busy_q;

   logic [NUM_REQ-1:0]  win_oh;
   logic [ID_W-1:0]     win_idx;
   logic                win_any;

   logic                fresh_hit;
   logic                tmo_hit;
   logic                done_ok;
   logic                tmo_fire;
   logic                rel_ok;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (bus.req),
      .ptr     (rr_ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .win_any (win_any)
   );

   // age < FRESH_CYCLES, phrased so a zero window folds away cleanly.
   assign fresh_hit = ({1'b0, age} + 17'd1) <= {1'b0, FRESH_CYCLES};
   assign tmo_hit   = (tmo_cnt == BUSY_TIMEOUT - 8'd1);

   // Next-state decode; stale snapshots wait in IDLE while an external sample is in flight.
   always_comb begin
      state_nxt  = state;
      id_nxt     = id_q;
      own_oh_nxt = own_oh;
      done_ok    = 1'b0;
      tmo_fire   = 1'b0;
      rel_ok     = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_any && (fresh_hit || !busy_q)) begin
               id_nxt     = win_idx;
               own_oh_nxt = win_oh;
               state_nxt  = fresh_hit ? S_GRANT : S_TRIG;
            end
         end
         S_TRIG:    state_nxt = S_WAIT_HI;
         S_WAIT_HI: begin
            if (busy_q) begin
               state_nxt = S_WAIT_LO;
            end else if (tmo_hit) begin
               tmo_fire  = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_WAIT_LO: begin
            if (!busy_q) begin
               done_ok   = 1'b1;
               state_nxt = S_GRANT;
            end else if (tmo_hit) begin
               tmo_fire  = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            if ((bus.rel & own_oh) != '0) begin
               rel_ok    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State, owner and round-robin pointer; pointer moves past the owner on release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         id_q   <= '0;
         own_oh <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         id_q   <= id_nxt;
         own_oh <= own_oh_nxt;
         if (rel_ok)
            rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
      end
   end

   // Busy is registered once at the boundary; the sampler runs from its own logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= 1'b0;
      else       busy_q <= bus.sample_busy;
   end

   // Timeout counter restarts on every state change and runs only while waiting on busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmo_cnt <= '0;
      else if (state_nxt != state)
         tmo_cnt <= '0;
      else if (state == S_WAIT_HI || state == S_WAIT_LO)
         tmo_cnt <= tmo_cnt + 8'd1;
   end

   // Snapshot age, completed-sample count and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         age         <= 16'hFFFF;
         sample_cnt  <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (done_ok)               age <= '0;
         else if (age != 16'hFFFF)  age <= age + 16'd1;
         if (done_ok)  sample_cnt  <= sample_cnt + 16'd1;
         if (tmo_fire) timeout_err <= 1'b1;
      end
   end

   // Grant and trigger are registered from next-state so both are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.gnt       <= '0;
         bus.do_sample <= 1'b0;
      end else begin
         bus.gnt       <= (state_nxt == S_GRANT) ? own_oh_nxt : '0;
         bus.do_sample <= (state_nxt == S_TRIG);
      end
   end

   // Owner's address reaches the sampler combinationally so block data is ready same cycle.
   always_comb begin
      bus.blk_addr = '0;
      if (state == S_GRANT)
         bus.blk_addr = bus.req_addr[id_q];
   end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed + randomized bench for sample_scheduler with a 5-cycle sampler model per DUT.
module tb_sample_scheduler;

   localparam int N   = 3;
   localparam int TMO = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset_d [2];
   logic [N-1:0]        req_d   [2];
   logic [N-1:0]        rel_d   [2];
   logic [N-1:0][4:0]   addr_d  [2];
   logic [N-1:0]        gnt_o   [2];
   logic [4:0]          blk_o   [2];
   logic                ds_o    [2];
   logic                busy_d  [2];
   logic [15:0]         cnt_o   [2];
   logic                terr_o  [2];
   bit                  smp_en  [2];
   bit                  ext_busy[2];
   logic [2:0]          rem     [2];
   int                  ds_cyc  [2];

   int n_assert = 0;
   int n_fail   = 0;

   sample_scheduler_if #(.NUM_REQ(N)) bus0 ();
   sample_scheduler_if #(.NUM_REQ(N)) bus1 ();

   assign bus0.req         = req_d[0];
   assign bus0.rel         = rel_d[0];
   assign bus0.req_addr    = addr_d[0];
   assign bus0.sample_busy = busy_d[0];
   assign gnt_o[0]         = bus0.gnt;
   assign blk_o[0]         = bus0.blk_addr;
   assign ds_o[0]          = bus0.do_sample;

   assign bus1.req         = req_d[1];
   assign bus1.rel         = rel_d[1];
   assign bus1.req_addr    = addr_d[1];
   assign bus1.sample_busy = busy_d[1];
   assign gnt_o[1]         = bus1.gnt;
   assign blk_o[1]         = bus1.blk_addr;
   assign ds_o[1]          = bus1.do_sample;

   sample_scheduler #(.NUM_REQ(N)) dut0 (
      .clk         (clk),
      .reset       (reset_d[0]),
      .bus         (bus0.slave),
      .sample_cnt  (cnt_o[0]),
      .timeout_err (terr_o[0])
   );

   sample_scheduler #(.NUM_REQ(N), .FRESH_CYCLES(16'd20)) dut1 (
      .clk         (clk),
      .reset       (reset_d[1]),
      .bus         (bus1.slave),
      .sample_cnt  (cnt_o[1]),
      .timeout_err (terr_o[1])
   );

   // Sampler model: busy for 5 cycles after a trigger; trigger cycles are tallied.
   assign busy_d[0] = (rem[0] != 3'd0) || ext_busy[0];
   assign busy_d[1] = (rem[1] != 3'd0) || ext_busy[1];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ds_cyc[d] <= ds_cyc[d] + (ds_o[d] ? 1 : 0);
         if (reset_d[d])                rem[d] <= 3'd0;
         else if (ds_o[d] && smp_en[d]) rem[d] <= 3'd5;
         else if (rem[d] != 3'd0)       rem[d] <= rem[d] - 3'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for any grant; also reports the wait index at which busy was first seen low.
   task automatic wait_gnt(input int d, input int maxc, output int lat, output int fall);
      logic prev;
      lat  = 0;
      fall = -100;
      while (gnt_o[d] == '0 && lat < maxc) begin
         prev = busy_d[d];
         @(negedge clk);
         lat++;
         if (prev && !busy_d[d] && fall < 0) fall = lat;
      end
      chk($sformatf("gnt_seen_dut%0d", d), 32'(gnt_o[d] != '0), 32'd1);
   endtask

   task automatic do_rel(input int d, input int w, input bit drop);
      rel_d[d] = 3'b001 << w;
      if (drop) req_d[d][w] = 1'b0;
      @(negedge clk);
      rel_d[d] = '0;
      chk($sformatf("gnt_drop_dut%0d", d), 32'(gnt_o[d]), 32'd0);
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, fall, w, ptr0, ptr1, scnt0, ds0;
      logic [2:0] t2_exp [4];
      t2_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

      for (int d = 0; d < 2; d++) begin
         reset_d[d] = 1'b1; req_d[d] = '0; rel_d[d] = '0; addr_d[d] = '0;
         smp_en[d] = 1'b1;  ext_busy[d] = 1'b0;
      end
      cyc(2);
      for (int d = 0; d < 2; d++) begin
         chk("rst_gnt",  32'(gnt_o[d]),  0);
         chk("rst_blk",  32'(blk_o[d]),  0);
         chk("rst_ds",   32'(ds_o[d]),   0);
         chk("rst_cnt",  32'(cnt_o[d]),  0);
         chk("rst_terr", 32'(terr_o[d]), 0);
      end
      reset_d[0] = 1'b0; reset_d[1] = 1'b0;
      cyc(1);

      // Single requester 1: one trigger, grant 2 cycles after busy falls.
      for (int i = 0; i < N; i++) addr_d[0][i] = 5'($urandom);
      ds0 = ds_cyc[0];
      req_d[0] = 3'b010;
      @(negedge clk); chk("t1_ds_hi", 32'(ds_o[0]), 1);
      @(negedge clk); chk("t1_ds_lo", 32'(ds_o[0]), 0);
      wait_gnt(0, 40, lat, fall);
      chk("t1_gnt",       32'(gnt_o[0]), 32'b010);
      chk("t1_fall2gnt",  32'(lat - fall), 2);
      chk("t1_ds_count",  32'(ds_cyc[0] - ds0), 1);
      chk("t1_cnt",       32'(cnt_o[0]), 1);
      chk("t1_blk",       32'(blk_o[0]), 32'(addr_d[0][1]));
      addr_d[0][1] = ~addr_d[0][1];
      #1 chk("t1_blk_follow", 32'(blk_o[0]), 32'(addr_d[0][1]));
      do_rel(0, 1, 1'b1);

      // All three requesting from pointer 0, each owner holds 4 cycles.
      reset_d[0] = 1'b1; @(negedge clk); reset_d[0] = 1'b0;
      scnt0 = 0; ptr0 = 0;
      req_d[0] = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(0, 60, lat, fall);
         chk("t2_order", 32'(gnt_o[0]), 32'(t2_exp[k]));
         scnt0++;
         chk("t2_cnt", 32'(cnt_o[0]), 32'(scnt0));
         w = rr_pick(req_d[0], ptr0);
         if (k < 3) begin
            cyc(3);
            chk("t2_hold", 32'(gnt_o[0]), 32'(t2_exp[k]));
            do_rel(0, w, 1'b0);
            ptr0 = (w + 1) % N;
         end
      end

      // Non-owner release is ignored; owner 0 keeps the grant.
      rel_d[0] = 3'b100; @(negedge clk); rel_d[0] = '0;
      cyc(3);
      chk("t6_hold", 32'(gnt_o[0]), 32'b001);
      chk("t6_cnt",  32'(cnt_o[0]), 32'(scnt0));
      req_d[0] = '0;
      do_rel(0, 0, 1'b0);
      ptr0 = 1;
      ds0 = ds_cyc[0];
      cyc(3);
      chk("idle_no_trig", 32'(ds_cyc[0] - ds0), 0);

      // Sampler already busy from elsewhere: trigger waits for it to drop.
      ext_busy[0] = 1'b1; cyc(2);
      ds0 = ds_cyc[0];
      req_d[0] = 3'b001;
      cyc(6);
      chk("ext_no_trig", 32'(ds_cyc[0] - ds0), 0);
      chk("ext_no_gnt",  32'(gnt_o[0]), 0);
      ext_busy[0] = 1'b0;
      wait_gnt(0, 60, lat, fall);
      chk("ext_gnt", 32'(gnt_o[0]), 32'b001);
      chk("ext_ds",  32'(ds_cyc[0] - ds0), 1);
      scnt0++;
      chk("ext_cnt", 32'(cnt_o[0]), 32'(scnt0));
      do_rel(0, 0, 1'b1);
      ptr0 = 1;

      // Randomized request mixes against the round-robin model, then drain.
      for (int it = 0; it < 14; it++) begin
         if (it < 10) req_d[0] = req_d[0] | 3'($urandom_range(1, 7));
         if (req_d[0] == '0) break;
         for (int i = 0; i < N; i++) addr_d[0][i] = 5'($urandom);
         ds0 = ds_cyc[0];
         w = rr_pick(req_d[0], ptr0);
         wait_gnt(0, 80, lat, fall);
         chk("rnd_gnt", 32'(gnt_o[0]), 32'(1) << w);
         chk("rnd_blk", 32'(blk_o[0]), 32'(addr_d[0][w]));
         scnt0++;
         chk("rnd_cnt", 32'(cnt_o[0]), 32'(scnt0));
         chk("rnd_ds",  32'(ds_cyc[0] - ds0), 1);
         cyc($urandom_range(0, 3));
         do_rel(0, w, 1'b1);
         ptr0 = (w + 1) % N;
      end

      // Reset while waiting for busy to fall; the held request is served again.
      req_d[0] = 3'b100;
      @(negedge clk); chk("t5_ds", 32'(ds_o[0]), 1);
      cyc(5);
      chk("t5_busy", 32'(busy_d[0]), 1);
      reset_d[0] = 1'b1;
      #1;
      chk("t5_gnt",  32'(gnt_o[0]),  0);
      chk("t5_ds0",  32'(ds_o[0]),   0);
      chk("t5_cnt",  32'(cnt_o[0]),  0);
      chk("t5_blk",  32'(blk_o[0]),  0);
      @(negedge clk); reset_d[0] = 1'b0;
      ds0 = ds_cyc[0];
      wait_gnt(0, 60, lat, fall);
      chk("t5_regnt", 32'(gnt_o[0]), 32'b100);
      chk("t5_recnt", 32'(cnt_o[0]), 1);
      chk("t5_reds",  32'(ds_cyc[0] - ds0), 1);
      do_rel(0, 2, 1'b1);

      // Sampler never answers: timeout after 32 cycles, grant anyway.
      smp_en[1] = 1'b0;
      ds0 = ds_cyc[1];
      req_d[1] = 3'b100;
      @(negedge clk); chk("t4_ds", 32'(ds_o[1]), 1);
      lat = 0;
      while (gnt_o[1] == '0 && lat < 80) begin
         @(negedge clk); lat++;
         if (lat == 20) chk("t4_terr_early", 32'(terr_o[1]), 0);
      end
      chk("t4_lat",  32'(lat), TMO + 1);
      chk("t4_gnt",  32'(gnt_o[1]), 32'b100);
      chk("t4_terr", 32'(terr_o[1]), 1);
      chk("t4_cnt",  32'(cnt_o[1]), 0);
      do_rel(1, 2, 1'b1);
      ptr1 = 0;

      // Age was not refreshed by the timeout, so the next request resamples.
      smp_en[1] = 1'b1;
      ds0 = ds_cyc[1];
      req_d[1] = 3'b001;
      w = rr_pick(req_d[1], ptr1);
      wait_gnt(1, 60, lat, fall);
      chk("t4_stale_gnt", 32'(gnt_o[1]), 32'(1) << w);
      chk("t4_stale_ds",  32'(ds_cyc[1] - ds0), 1);
      chk("t4_stale_cnt", 32'(cnt_o[1]), 1);
      chk("t4_terr_sticky", 32'(terr_o[1]), 1);
      do_rel(1, 0, 1'b1);

      // Fresh snapshot: request 10 cycles after busy fell is granted without sampling.
      cyc(10 - (lat - fall) - 1);
      ds0 = ds_cyc[1];
      req_d[1] = 3'b100;
      wait_gnt(1, 60, lat, fall);
      chk("t3_lat",  32'(lat), 1);
      chk("t3_gnt",  32'(gnt_o[1]), 32'b100);
      chk("t3_ds",   32'(ds_cyc[1] - ds0), 0);
      chk("t3_cnt",  32'(cnt_o[1]), 1);
      do_rel(1, 2, 1'b1);

      // Past the reuse window the snapshot is resampled.
      cyc(15);
      ds0 = ds_cyc[1];
      req_d[1] = 3'b001;
      wait_gnt(1, 60, lat, fall);
      chk("t3_old_ds",  32'(ds_cyc[1] - ds0), 1);
      chk("t3_old_cnt", 32'(cnt_o[1]), 2);

      // Reset while granted drops the grant and clears the sticky flag.
      reset_d[1] = 1'b1;
      req_d[1] = '0;
      #1;
      chk("rstg_gnt",  32'(gnt_o[1]),  0);
      chk("rstg_blk",  32'(blk_o[1]),  0);
      chk("rstg_terr", 32'(terr_o[1]), 0);
      chk("rstg_cnt",  32'(cnt_o[1]),  0);
      @(negedge clk); reset_d[1] = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
